tt_um_hoene_manchester_frame_ctrl: RTL and testbench

TT_UM_HOENE_MANCHESTER_FRAME_CTRL -- requirements
Module: tt_um_hoene_manchester_frame_ctrl

---
 rtl/tt_um_hoene_smart_led_pkg.sv | 15 +
 rtl/tt_um_hoene_word_shifter.sv | 38 +++
 rtl/tt_um_hoene_manchester_frame_ctrl.sv | 167 ++++++++++++++++
 tb/tb_tt_um_hoene_manchester_frame_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_um_hoene_smart_led_pkg.sv
// Shared types and default sizing for the smart-LED Manchester frame controller.
// Holds the frame FSM state encoding and the default word/gap/index parameters.
package tt_um_hoene_smart_led_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        READY     = 2'd1,
        SHIFT     = 2'd2
    } state_t;

    localparam int DEF_WORD_BITS   = 24;
    localparam int DEF_IDLE_CYCLES = 96;
    localparam int DEF_IDX_W       = 8;

endpackage

// File: rtl/tt_um_hoene_word_shifter.sv
// Word assembler: MSB-first shift register plus bit counter. word_next is the
// word that would be held after the current shift, so a completed word is usable same cycle.
module tt_um_hoene_word_shifter
    import tt_um_hoene_smart_led_pkg::*;
#(
    parameter int WORD_BITS = DEF_WORD_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 shift_en,
    input  logic                 bit_in,
    output logic [WORD_BITS-1:0] word_next,
    output logic                 word_done,
    output logic                 partial
);

    localparam int CNT_W = $clog2(WORD_BITS + 1);

    // Only WORD_BITS-1 bits need storing; the last bit arrives with word_done.
    logic [WORD_BITS-2:0] sreg;
    logic [CNT_W-1:0]     bit_cnt;

    assign word_next = {sreg, bit_in};
    assign word_done = shift_en && (bit_cnt == CNT_W'(WORD_BITS - 1));
    assign partial   = (bit_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            sreg    <= word_next[WORD_BITS-2:0];
            bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tt_um_hoene_manchester_frame_ctrl.sv
// Frame controller: turns decoded Manchester bits into indexed LED words with a
// valid/ready handshake. Define HOENE_FRAME_STATS_EN to enable the err_count counter.
module tt_um_hoene_manchester_frame_ctrl
    import tt_um_hoene_smart_led_pkg::*;
#(
    parameter int WORD_BITS   = DEF_WORD_BITS,
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
    parameter int IDX_W       = DEF_IDX_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_data,
    input  logic                 bit_clk,
    input  logic                 bit_error,
    output logic                 dec_rst_n,
    output logic [WORD_BITS-1:0] word_data,
    output logic [IDX_W-1:0]     word_idx,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic                 frame_end,
    output logic                 overrun,
    output logic                 frame_abort,
    output logic [7:0]           err_count
);

    localparam int GAP_W = $clog2(IDLE_CYCLES + 1);

    state_t               state, state_next;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 gap_hit;
    logic                 shift_en;
    logic                 shift_clear;
    logic                 abort_set;
    logic                 drop;
    logic                 word_done;
    logic                 partial;
    logic                 words_seen;
    logic [WORD_BITS-1:0] word_next;
    logic [IDX_W-1:0]     idx_cnt;

    tt_um_hoene_word_shifter #(
        .WORD_BITS(WORD_BITS)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .clear    (shift_clear),
        .shift_en (shift_en),
        .bit_in   (bit_data),
        .word_next(word_next),
        .word_done(word_done),
        .partial  (partial)
    );

    // Single-cycle event on the edge where the gap counter lands on IDLE_CYCLES.
    assign gap_hit = !bit_clk && (gap_cnt == GAP_W'(IDLE_CYCLES - 1));
    assign drop    = word_done && word_valid && !word_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (bit_clk) begin
            gap_cnt <= '0;
        end else if (gap_cnt != GAP_W'(IDLE_CYCLES)) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        shift_en    = 1'b0;
        shift_clear = gap_hit;
        abort_set   = 1'b0;
        case (state)
            READY: begin
                if (bit_clk) begin
                    shift_en   = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_error) begin
                    shift_clear = 1'b1;
                    abort_set   = 1'b1;
                    state_next  = WAIT_IDLE;
                end else if (bit_clk) begin
                    shift_en = 1'b1;
                end else if (gap_hit && partial) begin
                    abort_set = 1'b1;
                end
            end
            default: ;
        endcase
        if (gap_hit) begin
            state_next = READY;
        end
    end

    // Output stage: handshake, word index, frame flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_rst_n   <= 1'b0;
            word_data   <= '0;
            word_idx    <= '0;
            word_valid  <= 1'b0;
            idx_cnt     <= '0;
            words_seen  <= 1'b0;
            frame_end   <= 1'b0;
            overrun     <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            dec_rst_n <= 1'b1;
            frame_end <= gap_hit && words_seen;
            if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
            if (word_done) begin
                if (!drop) begin
                    word_data  <= word_next;
                    word_idx   <= idx_cnt;
                    word_valid <= 1'b1;
                end
                words_seen <= 1'b1;
                if (idx_cnt != '1) begin
                    idx_cnt <= idx_cnt + 1'b1;
                end
            end
            if (gap_hit) begin
                idx_cnt    <= '0;
                words_seen <= 1'b0;
                overrun    <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
            // A partial word cut by the gap still reports an abort across the frame boundary.
            if (abort_set) begin
                frame_abort <= 1'b1;
            end else if (gap_hit) begin
                frame_abort <= 1'b0;
            end
        end
    end

`ifdef HOENE_FRAME_STATS_EN
    logic err_event;
    assign err_event = abort_set || drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= 8'd0;
        end else if (err_event && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_tt_um_hoene_manchester_frame_ctrl.sv
// Directed testbench for tt_um_hoene_manchester_frame_ctrl with default parameters.
module tb_tt_um_hoene_manchester_frame_ctrl;
    import tt_um_hoene_smart_led_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bit_data = 1'b0;
    logic        bit_clk = 1'b0;
    logic        bit_error = 1'b0;
    logic        dec_rst_n;
    logic [23:0] word_data;
    logic [7:0]  word_idx;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic        frame_end;
    logic        overrun;
    logic        frame_abort;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    tt_um_hoene_manchester_frame_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .bit_data   (bit_data),
        .bit_clk    (bit_clk),
        .bit_error  (bit_error),
        .dec_rst_n  (dec_rst_n),
        .word_data  (word_data),
        .word_idx   (word_idx),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .frame_end  (frame_end),
        .overrun    (overrun),
        .frame_abort(frame_abort),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_bit(input logic b);
        bit_data = b;
        bit_clk  = 1'b1;
        tick();
        bit_clk  = 1'b0;
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic count_frame_end(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (frame_end === 1'b1) cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        checks++;
        if (dec_rst_n !== 1'b0) begin errors++; $display("FAIL reset_dec_rst_n got %b want 0", dec_rst_n); end
        checks++;
        if (word_valid !== 1'b0 || frame_end !== 1'b0 || overrun !== 1'b0 || frame_abort !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got v%b fe%b ov%b ab%b want all 0", word_valid, frame_end, overrun, frame_abort);
        end
        checks++;
        if (word_data !== 24'd0 || word_idx !== 8'd0) begin
            errors++; $display("FAIL reset_word got %h/%0d want 000000/0", word_data, word_idx);
        end
        checks++;
        if (dut.state !== WAIT_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dut.state, WAIT_IDLE); end
        checks++;
        if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got %0d want 0", err_count); end
        rst = 1'b0;
        tick();
        checks++;
        if (dec_rst_n !== 1'b1) begin errors++; $display("FAIL release_dec_rst_n got %b want 1", dec_rst_n); end
    endtask

    task automatic test_single_word();
        int fe;
        idle(100);
        checks++;
        if (dut.state !== READY) begin errors++; $display("FAIL single_ready_state got %0d want %0d", dut.state, READY); end
        word_ready = 1'b1;
        send_word(24'hA5C3F0);
        checks++;
        if (word_valid !== 1'b1 || word_data !== 24'hA5C3F0 || word_idx !== 8'd0) begin
            errors++;
            $display("FAIL single_word got v%b %h idx%0d want v1 a5c3f0 idx0", word_valid, word_data, word_idx);
        end
        tick();
        checks++;
        if (word_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop got %b want 0", word_valid); end
        count_frame_end(120, fe);
        checks++;
        if (fe != 1) begin errors++; $display("FAIL single_frame_end got %0d pulses want 1", fe); end
    endtask

    task automatic test_three_words();
        logic [23:0] w [3];
        w[0] = 24'h123456; w[1] = 24'hABCDEF; w[2] = 24'h000001;
        word_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send_word(w[k]);
            checks++;
            if (word_valid !== 1'b1 || word_data !== w[k] || word_idx !== 8'(k)) begin
                errors++;
                $display("FAIL three_word%0d got v%b %h idx%0d want v1 %h idx%0d", k, word_valid, word_data, word_idx, w[k], k);
            end
        end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL three_overrun got %b want 0", overrun); end
        idle(120);
    endtask

    task automatic test_overrun();
        word_ready = 1'b0;
        send_word(24'h111111);
        checks++;
        if (word_valid !== 1'b1 || word_data !== 24'h111111 || word_idx !== 8'd0) begin
            errors++; $display("FAIL ovr_first got v%b %h idx%0d want v1 111111 idx0", word_valid, word_data, word_idx);
        end
        send_word(24'h222222);
        checks++;
        if (word_valid !== 1'b1 || word_data !== 24'h111111 || word_idx !== 8'd0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_hold got v%b %h idx%0d ov%b want v1 111111 idx0 ov1", word_valid, word_data, word_idx, overrun);
        end
        word_ready = 1'b1;
        tick();
        checks++;
        if (word_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept got %b want 0", word_valid); end
        send_word(24'h333333);
        checks++;
        if (word_valid !== 1'b1 || word_data !== 24'h333333 || word_idx !== 8'd2) begin
            errors++; $display("FAIL ovr_third got v%b %h idx%0d want v1 333333 idx2", word_valid, word_data, word_idx);
        end
        idle(120);
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_gap_clear got %b want 0", overrun); end
    endtask

    task automatic test_bit_error();
        int   fe;
        logic seen;
        bit_error = 1'b1;
        idle(3);
        bit_error = 1'b0;
        checks++;
        if (frame_abort !== 1'b0 || dut.state !== READY) begin
            errors++; $display("FAIL err_ready_ignore got ab%b st%0d want ab0 st%0d", frame_abort, dut.state, READY);
        end
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        bit_error = 1'b1;
        tick();
        bit_error = 1'b0;
        checks++;
        if (frame_abort !== 1'b1 || dut.state !== WAIT_IDLE) begin
            errors++; $display("FAIL err_abort got ab%b st%0d want ab1 st%0d", frame_abort, dut.state, WAIT_IDLE);
        end
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            send_bit(i[0]);
            if (word_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL err_bits_ignored got valid %b want 0", seen); end
        count_frame_end(120, fe);
        checks++;
        if (fe != 0 || frame_abort !== 1'b0 || dut.state !== READY) begin
            errors++; $display("FAIL err_recover got fe%0d ab%b st%0d want fe0 ab0 st%0d", fe, frame_abort, dut.state, READY);
        end
        word_ready = 1'b1;
        send_word(24'h0F0F0F);
        checks++;
        if (word_valid !== 1'b1 || word_data !== 24'h0F0F0F || word_idx !== 8'd0) begin
            errors++; $display("FAIL err_next_word got v%b %h idx%0d want v1 0f0f0f idx0", word_valid, word_data, word_idx);
        end
        idle(120);
    endtask

    task automatic test_gap_abort();
        int fe;
        for (int i = 0; i < 12; i++) send_bit(1'b0);
        count_frame_end(120, fe);
        checks++;
        if (fe != 0 || frame_abort !== 1'b1 || dut.state !== READY) begin
            errors++; $display("FAIL gap_abort got fe%0d ab%b st%0d want fe0 ab1 st%0d", fe, frame_abort, dut.state, READY);
        end
    endtask

    task automatic test_reset_mid();
        word_ready = 1'b0;
        send_word(24'hFFFFFF);
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        rst = 1'b1;
        tick();
        checks++;
        if (word_valid !== 1'b0 || word_data !== 24'd0 || frame_abort !== 1'b0 || dec_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got v%b %h ab%b dr%b want v0 000000 ab0 dr0", word_valid, word_data, frame_abort, dec_rst_n);
        end
        rst = 1'b0;
        idle(100);
        word_ready = 1'b1;
        send_word(24'h5A5A5A);
        checks++;
        if (word_valid !== 1'b1 || word_data !== 24'h5A5A5A || word_idx !== 8'd0) begin
            errors++; $display("FAIL mid_reset_word got v%b %h idx%0d want v1 5a5a5a idx0", word_valid, word_data, word_idx);
        end
        idle(120);
    endtask

    task automatic test_err_count();
`ifdef HOENE_FRAME_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(100);
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 12; i++) send_bit(1'b1);
            idle(100);
            if (n == 0) begin
                checks++;
                if (err_count !== 8'd1) begin errors++; $display("FAIL stats_first got %0d want 1", err_count); end
            end
        end
        checks++;
        if (err_count !== 8'd255) begin errors++; $display("FAIL stats_saturate got %0d want 255", err_count); end
`else
        checks++;
        if (err_count !== 8'd0) begin errors++; $display("FAIL stats_tied got %0d want 0", err_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_three_words();
        test_overrun();
        test_bit_error();
        test_gap_abort();
        test_reset_mid();
        test_err_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
